// File: rtl/layer_compositor.sv
// Palette-based multi-layer pixel compositor: per-layer palette lookup, priority
// selection with transparency key and blinking, two-stage registered pipeline.
module layer_compositor #(
  parameter int unsigned NUM_LAYERS = 6,
  parameter int unsigned IDX_W      = 4,
  parameter logic [23:0] TRANSP_KEY = 24'hFF2FFF,
  parameter int unsigned BLINK_BIT  = 4
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          pix_valid,
  input  logic [NUM_LAYERS-1:0]         layer_hit,
  input  logic [NUM_LAYERS*IDX_W-1:0]   layer_idx,
  input  logic [NUM_LAYERS-1:0]         layer_vis,
  input  logic [NUM_LAYERS-1:0]         blink_en,
  input  logic                          vsync,
  input  logic                          pal_we,
  input  logic [$clog2(NUM_LAYERS)-1:0] pal_layer,
  input  logic [IDX_W-1:0]              pal_addr,
  input  logic [23:0]                   pal_data,
  output logic                          out_valid,
  output logic [7:0]                    VGA_R,
  output logic [7:0]                    VGA_G,
  output logic [7:0]                    VGA_B
);

  localparam int unsigned LAYER_W = $clog2(NUM_LAYERS);
  localparam int unsigned DEPTH   = 2 ** IDX_W;
  localparam int unsigned COL_W   = 24;

  logic [COL_W-1:0]      pal [NUM_LAYERS][DEPTH];
  logic                  pal_ok_c;
  logic                  vsync_q;
  logic                  vsync_prev;
  logic [7:0]            frame_cnt;
  logic                  blink_off_c;
  logic [COL_W-1:0]      col1 [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] hit1;
  logic                  vld1;
  logic [COL_W-1:0]      sel_c;
  logic [COL_W-1:0]      rgb;
  logic                  unused_bg_hit_c;

  assign pal_ok_c    = {1'b0, pal_layer} < (LAYER_W + 1)'(NUM_LAYERS);
  assign blink_off_c = frame_cnt[BLINK_BIT];

  // Palette storage; out-of-range layer writes are dropped
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int l = 0; l < int'(NUM_LAYERS); l++)
        for (int e = 0; e < int'(DEPTH); e++)
          pal[l][e] <= '0;
    end else if (pal_we && pal_ok_c) begin
      pal[pal_layer][pal_addr] <= pal_data;
    end
  end

  // Frame counter advances on a rising edge of the registered vsync
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vsync_q    <= 1'b0;
      vsync_prev <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      vsync_q    <= vsync;
      vsync_prev <= vsync_q;
      if (vsync_q && !vsync_prev)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Stage 1: palette lookup (reads pre-write contents) and effective hits
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld1 <= 1'b0;
      hit1 <= '0;
      for (int k = 0; k < int'(NUM_LAYERS); k++)
        col1[k] <= '0;
    end else begin
      vld1 <= pix_valid;
      hit1 <= layer_hit & layer_vis & ~(blink_en & {NUM_LAYERS{blink_off_c}});
      for (int k = 0; k < int'(NUM_LAYERS); k++)
        col1[k] <= pal[k][layer_idx[k*IDX_W +: IDX_W]];
    end
  end

  // Priority pick: lowest qualifying layer wins, background is the fallback
  always_comb begin
    sel_c = col1[NUM_LAYERS-1];
    for (int k = int'(NUM_LAYERS) - 2; k >= 0; k--) begin
      if (hit1[k] && (col1[k] != TRANSP_KEY))
        sel_c = col1[k];
    end
  end

  // The background is used unconditionally, so its hit flag never matters
  assign unused_bg_hit_c = hit1[NUM_LAYERS-1];

  // Stage 2: output register; colour holds while no pixel is valid
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_valid <= 1'b0;
      rgb       <= '0;
    end else begin
      out_valid <= vld1;
      if (vld1)
        rgb <= sel_c;
    end
  end

  assign VGA_R = rgb[23:16];
  assign VGA_G = rgb[15:8];
  assign VGA_B = rgb[7:0];

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: directed pixels push expected colours,
// a negedge monitor pops and checks colour and two-cycle latency.
module tb_layer_compositor;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        pix_valid = 1'b0;
  logic [5:0]  layer_hit = '0;
  logic [23:0] layer_idx = '0;
  logic [5:0]  layer_vis = '0;
  logic [5:0]  blink_en = '0;
  logic        vsync = 1'b0;
  logic        pal_we = 1'b0;
  logic [2:0]  pal_layer = '0;
  logic [3:0]  pal_addr = '0;
  logic [23:0] pal_data = '0;
  logic        out_valid;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  logic [23:0] exp_q[$];
  int          cyc_q[$];
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  bit          done = 1'b0;

  layer_compositor dut (
    .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .layer_hit(layer_hit),
    .layer_idx(layer_idx), .layer_vis(layer_vis), .blink_en(blink_en),
    .vsync(vsync), .pal_we(pal_we), .pal_layer(pal_layer), .pal_addr(pal_addr),
    .pal_data(pal_data), .out_valid(out_valid), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic step();
    @(posedge Clk);
    #1;
    pal_we    = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic wr(input logic [2:0] l, input logic [3:0] a, input logic [23:0] d);
    step();
    pal_we = 1'b1; pal_layer = l; pal_addr = a; pal_data = d;
  endtask

  task automatic pix(input logic [5:0] h, input logic [23:0] ix, input logic [5:0] v,
                     input logic [5:0] b, input logic [23:0] e);
    step();
    layer_hit = h; layer_idx = ix; layer_vis = v; blink_en = b; pix_valid = 1'b1;
    exp_q.push_back(e);
    cyc_q.push_back(cyc);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(); vsync = 1'b1;
      step();
      step(); vsync = 1'b0;
      step();
    end
    step();
    step();
  endtask

  // Monitor: only this process touches the counters
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge Clk) begin
    if (Reset) begin
      chk("reset_valid", 32'(out_valid), 32'd0);
      chk("reset_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'd0);
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        logic [23:0] e;
        int          c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        chk("rgb", {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, e});
        chk("latency", 32'(cyc - c), 32'd2);
      end
    end
    if (done) begin
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
    end
  end

  initial begin
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;

    // Basic lookup and background fallback
    wr(3'd0, 4'd3, 24'h112233);
    wr(3'd5, 4'd0, 24'hD1F7FF);
    pix(6'h01, 24'h000003, 6'h3F, 6'h00, 24'h112233);
    pix(6'h00, 24'h000003, 6'h3F, 6'h00, 24'hD1F7FF);

    // Transparent key falls through to lower priority / background
    wr(3'd0, 4'd3, 24'hFF2FFF);
    wr(3'd2, 4'd1, 24'hAB0000);
    pix(6'h05, 24'h000103, 6'h3F, 6'h00, 24'hAB0000);
    pix(6'h01, 24'h000103, 6'h3F, 6'h00, 24'hD1F7FF);

    // Visibility gating, and a keyed background still shown
    wr(3'd1, 4'd2, 24'h445566);
    pix(6'h03, 24'h000023, 6'h3F, 6'h00, 24'h445566);
    pix(6'h03, 24'h000023, 6'h3D, 6'h00, 24'hD1F7FF);
    wr(3'd5, 4'd1, 24'hFF2FFF);
    pix(6'h00, 24'h100000, 6'h3F, 6'h00, 24'hFF2FFF);

    // Write and read of the same entry in one cycle returns the old colour
    wr(3'd1, 4'd5, 24'h0000FF);
    pix(6'h02, 24'h000050, 6'h3F, 6'h00, 24'h0000FF);
    pal_we = 1'b1; pal_layer = 3'd1; pal_addr = 4'd5; pal_data = 24'h00FF00;
    pix(6'h02, 24'h000050, 6'h3F, 6'h00, 24'h00FF00);

    // Blinking follows frame_cnt bit 4 across the 8-bit wrap
    wr(3'd0, 4'd4, 24'hCAFE01);
    pix(6'h03, 24'h000054, 6'h3F, 6'h01, 24'hCAFE01);
    frames(16);
    pix(6'h03, 24'h000054, 6'h3F, 6'h01, 24'h00FF00);
    pix(6'h3F, 24'h000054, 6'h3F, 6'h3F, 24'hD1F7FF);
    frames(16);
    pix(6'h03, 24'h000054, 6'h3F, 6'h01, 24'hCAFE01);
    frames(208);
    pix(6'h03, 24'h000054, 6'h3F, 6'h01, 24'h00FF00);
    frames(16);
    pix(6'h03, 24'h000054, 6'h3F, 6'h01, 24'hCAFE01);

    // Out-of-range palette writes change nothing
    wr(3'd6, 4'd4, 24'h123456);
    pix(6'h03, 24'h000054, 6'h3F, 6'h00, 24'hCAFE01);
    pal_we = 1'b1; pal_layer = 3'd7; pal_addr = 4'd5; pal_data = 24'h123456;
    pix(6'h02, 24'h000054, 6'h3F, 6'h00, 24'h00FF00);
    pix(6'h01, 24'h000054, 6'h3F, 6'h00, 24'hCAFE01);

    // Mid-stream reset discards in-flight pixels and clears palettes
    pix(6'h01, 24'h000054, 6'h3F, 6'h00, 24'hCAFE01);
    pix(6'h01, 24'h000054, 6'h3F, 6'h00, 24'hCAFE01);
    pix(6'h01, 24'h000054, 6'h3F, 6'h00, 24'hCAFE01);
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    pix_valid = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    @(posedge Clk);
    #1 Reset = 1'b0;
    step();
    pix(6'h3F, 24'h123454, 6'h3F, 6'h00, 24'h000000);
    pix(6'h00, 24'h100054, 6'h3F, 6'h00, 24'h000000);
    repeat (5) step();
    done = 1'b1;
  end

endmodule

// File: doc/layer_compositor.md
LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 The block SHALL have parameter NUM_LAYERS, default 6, meaning the number of sprite/tile layers; layer 0 has the highest priority.
REQ-002 The block SHALL have parameter IDX_W, default 4, meaning the palette index width per layer; each palette is 2**IDX_W entries.
REQ-003 The block SHALL have parameter TRANSP_KEY, default 24'hFF2FFF, meaning the colour treated as transparent.
REQ-004 The block SHALL have parameter BLINK_BIT, default 4, meaning the frame-counter bit that gates blinking layers.
REQ-005 The block SHALL have port Clk, input, 1, the single clock.
REQ-006 The block SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port pix_valid, input, 1, meaning the current pixel inputs are valid.
REQ-008 The block SHALL have port layer_hit, input, NUM_LAYERS, meaning the per-layer "pixel belongs to layer" flag.
REQ-009 The block SHALL have port layer_idx, input, NUM_LAYERS*IDX_W, meaning the packed per-layer palette index; layer k is at bits [k*IDX_W +: IDX_W].
REQ-010 The block SHALL have port layer_vis, input, NUM_LAYERS, meaning the per-layer visibility enable.
REQ-011 The block SHALL have port blink_en, input, NUM_LAYERS, meaning the per-layer blink enable.
REQ-012 The block SHALL have port vsync, input, 1, meaning the frame sync; its rising edge advances the frame counter.
REQ-013 The block SHALL have port pal_we, input, 1, meaning the palette write strobe.
REQ-014 The block SHALL have port pal_layer, input, $clog2(NUM_LAYERS), meaning the target palette of a write.
REQ-015 The block SHALL have port pal_addr, input, IDX_W, meaning the palette entry of a write.
REQ-016 The block SHALL have port pal_data, input, 24, meaning the RGB write data.
REQ-017 The block SHALL have port out_valid, output, 1, meaning VGA_R/G/B are valid.
REQ-018 The block SHALL have ports VGA_R, VGA_G and VGA_B, output, 8 each, meaning the composited pixel colour.

Function
REQ-019 Palettes SHALL be NUM_LAYERS register arrays of 2**IDX_W x 24 bits.
- Written on a rising Clk edge when pal_we=1.
- A write with pal_layer >= NUM_LAYERS SHALL be ignored.
REQ-020 Pipeline stage 1 SHALL register, per layer:
- the palette colour looked up by layer_idx;
- an effective-hit flag = layer_hit & layer_vis & ~(blink_en & frame_cnt[BLINK_BIT]);
- pix_valid.
REQ-021 A palette write and a stage-1 read of the same entry in the same cycle SHALL return the old colour; the new colour is visible from the next cycle.
REQ-022 Stage 2 SHALL select the lowest-numbered layer whose effective hit = 1 and whose looked-up colour != TRANSP_KEY, then register the result as {VGA_R, VGA_G, VGA_B} together with out_valid.
REQ-023 Layer NUM_LAYERS-1 is the background layer and SHALL be used whenever no layer qualifies, regardless of its hit, visibility, blink or key state.
REQ-024 Latency from pix_valid/inputs to out_valid/colour SHALL be exactly 2 Clk cycles, with throughput of 1 pixel per cycle and no stalls.
REQ-025 When pix_valid=0, out_valid SHALL be 0 two cycles later; the colour outputs are then don't-care but SHALL hold their previous value.
REQ-026 vsync SHALL be registered once; a 0->1 transition of the registered value SHALL increment an 8-bit frame_cnt, which wraps 255->0.
REQ-027 A change of frame_cnt[BLINK_BIT] SHALL affect only pixels sampled after the increment edge.

Reset
REQ-028 While Reset=1, the block SHALL clear the following asynchronously:
- VGA_R/G/B = 0;
- out_valid = 0;
- frame_cnt = 0;
- the vsync register = 0;
- all pipeline registers = 0;
- all palette entries = 24'h000000.
REQ-029 Reset asserted mid-frame SHALL discard in-flight pixels; the first out_valid after deassertion SHALL occur 2 cycles after the first accepted pix_valid.

Verification
REQ-030 Write layer0[3]=24'h112233 and background[0]=24'hD1F7FF; drive hit0=1, vis0=1, idx0=3, bg idx=0 -> after 2 cycles out_valid=1 and RGB=11/22/33.
REQ-031 Set layer0[3]=24'hFF2FFF and layer2[1]=24'hAB0000 with hit0=hit2=1 -> RGB=AB/00/00; with hit2=0 as well -> the background colour.
REQ-032 Write palette entry layer1[5]=24'h00FF00 in the same cycle that layer 1 reads idx 5 (old value 24'h0000FF) -> that pixel outputs 0000FF and the next pixel outputs 00FF00.
REQ-033 Set blink_en0=1 and apply 16 vsync rising edges with BLINK_BIT=4 -> layer 0 hidden (lower layer shown); after 32 edges layer 0 is visible again; after 256 edges frame_cnt=0.
REQ-034 Assert Reset for 1 cycle with out_valid=1 mid-stream -> outputs 0 immediately, palettes all 0, and out_valid returns 2 cycles after pix_valid resumes.
REQ-035 Issue pal_we with pal_layer=NUM_LAYERS -> no palette changes and no output disturbance.
